// File: rtl/wf_pkg.sv
// wf_pkg: shared state encoding and constants for the waveform player
package wf_pkg;
  typedef enum logic [1:0] {IDLE, ARM, PLAY, DRAIN} state_t;
  localparam logic [15:0] REPEAT_INF = 16'd0;
  localparam logic [31:0] CNT_MAX = 32'hffff_ffff;
endpackage

// File: rtl/wf_player_seq_sync.sv
// wf_sync_edge: 2-FF synchroniser with rising-edge pulse for an asynchronous pin
module wf_sync_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_rise
);
  logic [2:0] sr;
  always_ff @(posedge i_clk or negedge i_rst)
    if (!i_rst) sr <= '0;
    else sr <= {sr[1:0], i_d};
  assign o_rise = sr[1] & ~sr[2];
endmodule

// File: rtl/wf_player_seq.sv
// wf_player_seq: BRAM-backed waveform player with one-shot, N-repeat and loop modes
module wf_player_seq
  import wf_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int RD_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_dsp_wf_start,
  input  logic              i_sw_start,
  input  logic              i_sw_stop,
  input  logic              i_wf_read_cnt,
  input  logic              i_wf_write_en,
  input  logic [ADDR_W-1:0] i_wf_write_addr,
  input  logic [DATA_W-1:0] i_wf_write_data,
  input  logic [ADDR_W:0]   i_wf_length,
  input  logic [15:0]       i_wf_repeat,
  output logic [ADDR_W-1:0] o_xintf_wf_ram_addr,
  output logic              o_xintf_wf_ram_ce,
  output logic              o_xintf_wf_ram_we,
  output logic [DATA_W-1:0] o_xintf_wf_ram_din,
  input  logic [DATA_W-1:0] i_xintf_wf_ram_dout,
  output logic [DATA_W-1:0] o_wf_data,
  output logic              o_wf_data_valid,
  output logic              o_dsp_wf_mode,
  output logic              o_wf_busy,
  output logic              o_wf_done,
  output logic              o_wf_err,
  output logic [31:0]       o_wf_read_data_num,
  output logic [15:0]       o_wf_loop_num
);
  state_t state, nxt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0] len_q;
  logic [15:0] rep_q;
  logic [RD_LAT:0] v_pipe, d_pipe;
  logic dsp_rise, start, stop, len_ok, accept, rd_fire, last, fin, wr_ok, err_set;
  wf_sync_edge u_sync (.i_clk(i_clk), .i_rst(i_rst), .i_d(i_dsp_wf_start), .o_rise(dsp_rise));
  assign start   = dsp_rise | i_sw_start;
  assign stop    = i_sw_stop && state != IDLE;
  assign len_ok  = i_wf_length != '0 && i_wf_length <= (ADDR_W+1)'(DEPTH);
  assign accept  = state == IDLE && start && !i_sw_stop && len_ok;
  assign rd_fire = state == PLAY && i_wf_read_cnt && !i_sw_stop;
  assign last    = {1'b0, ptr} == len_q - 1'b1;
  assign fin     = rd_fire && last && rep_q != REPEAT_INF && {1'b0, o_wf_loop_num} + 17'd1 >= {1'b0, rep_q};
  assign wr_ok   = state == IDLE && i_wf_write_en;
  assign err_set = (state == IDLE && start && !i_sw_stop && !len_ok) ||
                   (i_wf_write_en && state != IDLE) || (i_wf_read_cnt && state != PLAY);
  assign o_dsp_wf_mode = state != IDLE;
  assign o_wf_busy     = state != IDLE;
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    nxt = accept ? ARM : IDLE;
      ARM:     nxt = stop ? IDLE : PLAY;
      PLAY:    nxt = stop ? IDLE : fin ? DRAIN : PLAY;
      DRAIN:   nxt = (stop || v_pipe == '0) ? IDLE : DRAIN;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst)
    if (!i_rst) state <= IDLE;
    else state <= nxt;
  // Valid/done travel alongside the BRAM read so abort can squash them in flight
  always_ff @(posedge i_clk or negedge i_rst)
    if (!i_rst) begin
      v_pipe <= '0;
      d_pipe <= '0;
      o_wf_data_valid <= 1'b0;
      o_wf_done <= 1'b0;
      o_wf_data <= '0;
      o_xintf_wf_ram_ce <= 1'b0;
      o_xintf_wf_ram_we <= 1'b0;
      o_xintf_wf_ram_addr <= '0;
      o_xintf_wf_ram_din <= '0;
      o_wf_err <= 1'b0;
      ptr <= '0;
      len_q <= '0;
      rep_q <= '0;
      o_wf_read_data_num <= '0;
      o_wf_loop_num <= '0;
    end else begin
      v_pipe <= stop ? '0 : {v_pipe[RD_LAT-1:0], rd_fire};
      d_pipe <= stop ? '0 : {d_pipe[RD_LAT-1:0], fin};
      o_wf_data_valid <= v_pipe[RD_LAT] && !stop;
      o_wf_done <= d_pipe[RD_LAT] && !stop;
      if (v_pipe[RD_LAT]) o_wf_data <= i_xintf_wf_ram_dout;
      o_xintf_wf_ram_ce <= wr_ok || rd_fire;
      o_xintf_wf_ram_we <= wr_ok;
      if (wr_ok) begin
        o_xintf_wf_ram_addr <= i_wf_write_addr;
        o_xintf_wf_ram_din <= i_wf_write_data;
      end else if (rd_fire) o_xintf_wf_ram_addr <= ptr;
      o_wf_err <= err_set ? 1'b1 : accept ? 1'b0 : o_wf_err;
      if (accept) begin
        ptr <= '0;
        len_q <= i_wf_length;
        rep_q <= i_wf_repeat;
        o_wf_read_data_num <= '0;
        o_wf_loop_num <= '0;
      end else if (rd_fire) begin
        ptr <= last ? '0 : ptr + 1'b1;
        o_wf_read_data_num <= o_wf_read_data_num == CNT_MAX ? CNT_MAX : o_wf_read_data_num + 32'd1;
        if (last) o_wf_loop_num <= o_wf_loop_num + 16'd1;
      end
    end
endmodule
